aggr_line_scheduler: RTL and testbench

Frame/row sequencer for one SGM path-aggregation line buffer. It accepts the per-pixel cost stream with a valid/ready handshake and generates column and row position flags for the aggregation datapath. It drives the line-buffer SRAM read port (previous-row fetch) and the delayed write port (current-row aggregated cost written back after the datapath latency). It sits between the census/cost stage and the aggregation datapath, and it replaces free-running per-direction address counters.

---
 rtl/aggr_line_scheduler_if.sv | 48 ++++
 rtl/aggr_line_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_aggr_line_scheduler.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aggr_line_scheduler_if.sv
// ============================================================================
// Module      : aggr_line_scheduler_if
// Description : Cost-stream handshake, position flags and line-buffer SRAM
//               port bundle for the SGM aggregation line scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aggr_line_scheduler_if #(
    parameter int AWIDTH = 11,
    parameter int HWIDTH = 11
);
    logic              start;
    logic [AWIDTH-1:0] width;
    logic [HWIDTH-1:0] height;
    logic              in_valid;
    logic              in_ready;
    logic              px_valid;
    logic [AWIDTH-1:0] col;
    logic [HWIDTH-1:0] row;
    logic              first_row;
    logic              first_col;
    logic              last_col;
    logic              last_row;
    logic              sram_ren_n;
    logic [AWIDTH-1:0] rd_addr;
    logic              sram_wen_n;
    logic [AWIDTH-1:0] wr_addr;
    logic              busy;
    logic              frame_done;
    logic              cfg_err;

    modport master (
        output start, width, height, in_valid,
        input  in_ready, px_valid, col, row, first_row, first_col, last_col,
               last_row, sram_ren_n, rd_addr, sram_wen_n, wr_addr, busy,
               frame_done, cfg_err
    );

    modport slave (
        input  start, width, height, in_valid,
        output in_ready, px_valid, col, row, first_row, first_col, last_col,
               last_row, sram_ren_n, rd_addr, sram_wen_n, wr_addr, busy,
               frame_done, cfg_err
    );
endinterface

`default_nettype wire

// File: rtl/aggr_line_scheduler.sv
// ============================================================================
// Module      : aggr_line_scheduler
// Description : Frame/row sequencer for one SGM aggregation line buffer:
//               pixel acceptance, position flags, SRAM read and delayed write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aggr_line_scheduler #(
    parameter int AWIDTH  = 11,
    parameter int HWIDTH  = 11,
    parameter int LAT     = 3,
    parameter int ROW_GAP = 2
) (
    input wire clk,
    input wire rst,
    aggr_line_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_GAP   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [AWIDTH:0] MIN_WIDTH = (AWIDTH+1)'(LAT + 2);
    localparam logic [3:0]      GAP_LAST  = 4'((ROW_GAP > 0) ? ROW_GAP - 1 : 0);

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] width_q, width_d;
    logic [HWIDTH-1:0] height_q, height_d;
    logic [AWIDTH-1:0] col_cnt_q, col_cnt_d;
    logic [HWIDTH-1:0] row_cnt_q, row_cnt_d;
    logic [3:0]        gap_q, gap_d;

    logic              px_valid_q;
    logic [AWIDTH-1:0] col_q;
    logic [HWIDTH-1:0] row_q;
    logic              first_row_q, first_col_q, last_col_q, last_row_q;
    logic              ren_n_q;
    logic [AWIDTH-1:0] rd_addr_q;
    logic              cfg_err_q;

    logic [LAT-1:0]    pipe_v_q;
    logic [AWIDTH-1:0] pipe_c_q [LAT];

    logic              w_accept;
    logic              w_cfg_ok;
    logic              w_col_last;
    logic              w_row_last;
    logic              w_pipe_inner;
    logic [AWIDTH-1:0] w_width_m1;
    logic [HWIDTH-1:0] w_height_m1;

    assign w_accept    = bus.in_valid && (state_q == S_RUN);
    assign w_cfg_ok    = ({1'b0, bus.width} >= MIN_WIDTH) && (bus.height != '0);
    assign w_width_m1  = width_q - 1'b1;
    assign w_height_m1 = height_q - 1'b1;
    assign w_col_last  = (col_cnt_q == w_width_m1);
    assign w_row_last  = (row_cnt_q == w_height_m1);

    // Last pipe stage is the write itself; drain ends once nothing sits behind it.
    if (LAT > 1) begin : g_pipe_inner
        assign w_pipe_inner = |pipe_v_q[LAT-2:0];
    end else begin : g_pipe_single
        assign w_pipe_inner = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            width_q   <= '0;
            height_q  <= '0;
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            width_q   <= width_d;
            height_q  <= height_d;
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
            gap_q     <= gap_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        height_d  = height_q;
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        gap_d     = gap_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && w_cfg_ok) begin
                    width_d   = bus.width;
                    height_d  = bus.height;
                    col_cnt_d = '0;
                    row_cnt_d = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (w_accept) begin
                    if (w_col_last) begin
                        col_cnt_d = '0;
                        if (w_row_last) begin
                            state_d = S_DRAIN;
                        end else begin
                            row_cnt_d = row_cnt_q + 1'b1;
                            if (ROW_GAP > 0) begin
                                state_d = S_GAP;
                                gap_d   = '0;
                            end
                        end
                    end else begin
                        col_cnt_d = col_cnt_q + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) state_d = S_RUN;
                else                   gap_d   = gap_q + 1'b1;
            end
            S_DRAIN: begin
                if (!px_valid_q && !w_pipe_inner) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            px_valid_q  <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            first_row_q <= 1'b0;
            first_col_q <= 1'b0;
            last_col_q  <= 1'b0;
            last_row_q  <= 1'b0;
            ren_n_q     <= 1'b1;
            rd_addr_q   <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            px_valid_q  <= w_accept;
            first_row_q <= w_accept && (row_cnt_q == '0);
            first_col_q <= w_accept && (col_cnt_q == '0);
            last_col_q  <= w_accept && w_col_last;
            last_row_q  <= w_accept && w_row_last;
            ren_n_q     <= !(w_accept && (row_cnt_q != '0));
            cfg_err_q   <= (state_q == S_IDLE) && bus.start && !w_cfg_ok;
            if (w_accept) begin
                col_q <= col_cnt_q;
                row_q <= row_cnt_q;
            end
            // Row 0 has no previous row to fetch.
            if (w_accept && (row_cnt_q != '0)) rd_addr_q <= col_cnt_q;
        end
    end

    // Write-back delay line; the output stage only loads on a valid entry so
    // wr_addr holds its last value between writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_v_q <= '0;
            for (int i = 0; i < LAT; i++) pipe_c_q[i] <= '0;
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                pipe_v_q[i] <= pipe_v_q[i-1];
                if ((i < LAT - 1) || pipe_v_q[i-1]) pipe_c_q[i] <= pipe_c_q[i-1];
            end
            pipe_v_q[0] <= px_valid_q;
            if ((LAT > 1) || px_valid_q) pipe_c_q[0] <= col_q;
        end
    end

    assign bus.in_ready   = (state_q == S_RUN);
    assign bus.px_valid   = px_valid_q;
    assign bus.col        = col_q;
    assign bus.row        = row_q;
    assign bus.first_row  = first_row_q;
    assign bus.first_col  = first_col_q;
    assign bus.last_col   = last_col_q;
    assign bus.last_row   = last_row_q;
    assign bus.sram_ren_n = ren_n_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.sram_wen_n = !pipe_v_q[LAT-1];
    assign bus.wr_addr    = pipe_c_q[LAT-1];
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.frame_done = (state_q == S_DONE);
    assign bus.cfg_err    = cfg_err_q;

endmodule

`default_nettype wire

// File: tb/tb_aggr_line_scheduler.sv
// ============================================================================
// Module      : tb_aggr_line_scheduler
// Description : Directed self-checking bench for aggr_line_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aggr_line_scheduler;

    localparam int LAT = 3;

    logic clk;
    logic rst;
    logic sel;
    int   n_checks;
    int   n_fail;
    int   exp_rd;
    int   exp_wr;

    aggr_line_scheduler_if #(.AWIDTH(11), .HWIDTH(11)) ifc  ();
    aggr_line_scheduler_if #(.AWIDTH(11), .HWIDTH(11)) ifc0 ();

    aggr_line_scheduler #(.AWIDTH(11), .HWIDTH(11), .LAT(LAT), .ROW_GAP(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    aggr_line_scheduler #(.AWIDTH(11), .HWIDTH(11), .LAT(LAT), .ROW_GAP(0)) u_dut_nogap (
        .clk (clk),
        .rst (rst),
        .bus (ifc0.slave)
    );

    wire        o_ready = sel ? ifc0.in_ready   : ifc.in_ready;
    wire        o_px    = sel ? ifc0.px_valid   : ifc.px_valid;
    wire [10:0] o_col   = sel ? ifc0.col        : ifc.col;
    wire [10:0] o_row   = sel ? ifc0.row        : ifc.row;
    wire        o_fr    = sel ? ifc0.first_row  : ifc.first_row;
    wire        o_fc    = sel ? ifc0.first_col  : ifc.first_col;
    wire        o_lc    = sel ? ifc0.last_col   : ifc.last_col;
    wire        o_lr    = sel ? ifc0.last_row   : ifc.last_row;
    wire        o_ren   = sel ? ifc0.sram_ren_n : ifc.sram_ren_n;
    wire [10:0] o_rd    = sel ? ifc0.rd_addr    : ifc.rd_addr;
    wire        o_wen   = sel ? ifc0.sram_wen_n : ifc.sram_wen_n;
    wire [10:0] o_wr    = sel ? ifc0.wr_addr    : ifc.wr_addr;
    wire        o_busy  = sel ? ifc0.busy       : ifc.busy;
    wire        o_done  = sel ? ifc0.frame_done : ifc.frame_done;
    wire        o_err   = sel ? ifc0.cfg_err    : ifc.cfg_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of test, expected end within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_start(input bit s);
        if (sel) ifc0.start = s;
        else     ifc.start  = s;
    endtask

    task automatic set_cfg(input int w, input int h);
        ifc.width   = 11'(w);
        ifc.height  = 11'(h);
        ifc0.width  = 11'(w);
        ifc0.height = 11'(h);
    endtask

    task automatic set_valid(input bit v);
        ifc.in_valid  = v;
        ifc0.in_valid = v;
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_in_ready"},   o_ready, 0);
        chk({pfx, "_px_valid"},   o_px,    0);
        chk({pfx, "_flags"},      {o_fr, o_fc, o_lc, o_lr}, 0);
        chk({pfx, "_sram_ren_n"}, o_ren,   1);
        chk({pfx, "_sram_wen_n"}, o_wen,   1);
        chk({pfx, "_rd_addr"},    o_rd,    0);
        chk({pfx, "_wr_addr"},    o_wr,    0);
        chk({pfx, "_busy"},       o_busy,  0);
        chk({pfx, "_frame_done"}, o_done,  0);
        chk({pfx, "_cfg_err"},    o_err,   0);
    endtask

    // Drives one frame and checks every cycle against a position schedule
    // built from the accepts seen so far.
    task automatic run_frame(input int w, input int h, input int g, input int mode,
                             input int mid_start, input int abort_at);
        bit av [400];
        int ar [400];
        int ac [400];
        int rr, cc, gapleft, last;
        bit run, v, acc, pv, wv, finished;
        int pr, pc;
        rr = 0; cc = 0; gapleft = 0; last = -1; run = 1'b1; finished = 1'b0;
        set_cfg(w, h);
        set_start(1'b1);
        step();
        set_start(1'b0);
        chk("busy_after_start", o_busy, 1);
        for (int cyc = 0; cyc < 400; cyc++) begin
            v = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            set_valid(v);
            set_start(cyc == mid_start);
            set_cfg(w, (cyc == mid_start) ? 1 : h);

            chk("in_ready", o_ready, run);
            pv = (cyc > 0) && av[cyc-1];
            pr = (cyc > 0) ? ar[cyc-1] : 0;
            pc = (cyc > 0) ? ac[cyc-1] : 0;
            chk("px_valid", o_px, pv);
            if (pv) begin
                chk("col", o_col, pc);
                chk("row", o_row, pr);
                chk("first_row", o_fr, pr == 0);
                chk("first_col", o_fc, pc == 0);
                chk("last_col",  o_lc, pc == w - 1);
                chk("last_row",  o_lr, pr == h - 1);
            end
            chk("sram_ren_n", o_ren, !(pv && pr > 0));
            if (pv && pr > 0) exp_rd = pc;
            chk("rd_addr", o_rd, exp_rd);
            wv = (cyc > LAT) && av[cyc-1-LAT];
            chk("sram_wen_n", o_wen, !wv);
            if (wv) exp_wr = ac[cyc-1-LAT];
            chk("wr_addr", o_wr, exp_wr);
            chk("frame_done", o_done, (last >= 0) && (cyc == last + LAT + 2));
            chk("busy", o_busy, !((last >= 0) && (cyc > last + LAT + 2)));
            chk("cfg_err", o_err, 0);

            if (cyc == abort_at) begin
                rst = 1'b0;
                #1;
                check_reset_vals("abort_now");
                step();
                check_reset_vals("abort_next");
                exp_rd = 0;
                exp_wr = 0;
                set_valid(1'b0);
                rst = 1'b1;
                step();
                return;
            end
            if ((last >= 0) && (cyc == last + LAT + 3)) begin
                finished = 1'b1;
                break;
            end

            acc = v && run;
            av[cyc] = acc;
            ar[cyc] = rr;
            ac[cyc] = cc;
            if (acc) begin
                if (cc == w - 1) begin
                    if (rr == h - 1) begin
                        run  = 1'b0;
                        last = cyc;
                    end else begin
                        cc = 0;
                        rr++;
                        if (g > 0) begin
                            run     = 1'b0;
                            gapleft = g;
                        end
                    end
                end else begin
                    cc++;
                end
            end else if (!run && gapleft > 0) begin
                gapleft--;
                if (gapleft == 0) run = 1'b1;
            end
            step();
        end
        set_valid(1'b0);
        set_start(1'b0);
        if (!finished) chk("frame_timeout", 0, 1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_rd   = 0;
        exp_wr   = 0;
        sel      = 1'b0;
        rst      = 1'b0;
        ifc.start  = 1'b0;
        ifc0.start = 1'b0;
        set_valid(1'b0);
        set_cfg(8, 3);
        step();
        step();
        check_reset_vals("reset");
        rst = 1'b1;
        step();
        check_reset_vals("idle");

        // Full frame, continuous input
        run_frame(8, 3, 2, 0, -1, -1);
        // Same frame, input valid toggling
        run_frame(8, 3, 2, 1, -1, -1);

        // Rejected configurations
        set_cfg(4, 3);
        set_start(1'b1);
        step();
        set_start(1'b0);
        chk("narrow_cfg_err", o_err, 1);
        chk("narrow_busy", o_busy, 0);
        chk("narrow_ren_n", o_ren, 1);
        chk("narrow_wen_n", o_wen, 1);
        step();
        chk("narrow_cfg_err_pulse", o_err, 0);
        chk("narrow_busy2", o_busy, 0);
        chk("narrow_in_ready", o_ready, 0);
        set_cfg(8, 0);
        set_start(1'b1);
        step();
        set_start(1'b0);
        chk("h0_cfg_err", o_err, 1);
        chk("h0_busy", o_busy, 0);
        step();
        chk("h0_cfg_err_pulse", o_err, 0);
        chk("h0_ren_n", o_ren, 1);
        chk("h0_wen_n", o_wen, 1);
        chk("h0_busy2", o_busy, 0);

        // start pulsed mid-frame must be ignored
        run_frame(8, 3, 2, 0, 6, -1);
        // Reset asserted mid-row 1, then a clean frame
        run_frame(8, 3, 2, 0, -1, 12);
        run_frame(8, 3, 2, 0, -1, -1);

        // No inter-row gap, narrow frame
        sel    = 1'b1;
        exp_rd = 0;
        exp_wr = 0;
        step();
        check_reset_vals("nogap_idle");
        run_frame(5, 2, 0, 0, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
